// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and width helpers for the boot-time configuration loader.
package bp_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle  = 3'd0,
    e_fetch = 3'd1,
    e_send  = 3'd2,
    e_wait  = 3'd3,
    e_done  = 3'd4
  } bp_cfg_loader_state_e;

  typedef enum logic {
    e_phase_write = 1'b0,
    e_phase_read  = 1'b1
  } bp_cfg_phase_e;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int lg_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cfg_loader_counter.sv
// Clearable up-counter that wraps to zero after max_val_p.
module bp_cfg_loader_counter #(
  parameter int max_val_p = 1,
  parameter int width_p   = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      count_o <= '0;
    else if (clear_i)
      count_o <= '0;
    else if (up_i)
      count_o <= (count_o == max_lp) ? '0 : count_o + 1'b1;
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time config master: writes every table entry to every core, then reads
// each back and records the first mismatch.
//
// state   | meaning
// e_idle  | waiting for start_i after reset
// e_fetch | table index on rom_addr_o, entry captured at end of cycle
// e_send  | command valid, held until cfg_ready_i
// e_wait  | waiting for the single outstanding response
// e_done  | all writes and reads complete, done_o held
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int table_els_p      = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int lg_num_core_lp   = lg_f(num_core_p),
  parameter int lg_table_els_lp  = lg_f(table_els_p)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     start_i,
  output logic [lg_table_els_lp-1:0]               rom_addr_o,
  input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] rom_data_i,
  output logic                                     cfg_v_o,
  output logic                                     cfg_w_o,
  output logic [lg_num_core_lp-1:0]                cfg_core_o,
  output logic [cfg_addr_width_p-1:0]              cfg_addr_o,
  output logic [cfg_data_width_p-1:0]              cfg_data_o,
  input  logic                                     cfg_ready_i,
  input  logic                                     cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0]              cfg_resp_data_i,
  output logic                                     cfg_resp_ready_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     error_o,
  output logic [lg_num_core_lp-1:0]                err_core_o,
  output logic [lg_table_els_lp-1:0]               err_idx_o
);

  bp_cfg_loader_state_e              state_r;
  bp_cfg_phase_e                     phase_r;
  logic [cfg_addr_width_p-1:0]       entry_addr_r;
  logic [cfg_data_width_p-1:0]       entry_data_r;
  logic [lg_table_els_lp-1:0]        idx_r;
  logic [lg_num_core_lp-1:0]         core_r;
  logic                              start_ok;
  logic                              resp_fire;
  logic                              idx_last;
  logic                              core_last;

  assign start_ok  = start_i & ((state_r == e_idle) | (state_r == e_done));
  assign resp_fire = (state_r == e_wait) & cfg_resp_v_i;
  assign idx_last  = (idx_r == lg_table_els_lp'(table_els_p - 1));
  assign core_last = (core_r == lg_num_core_lp'(num_core_p - 1));

  bp_cfg_loader_counter #(
    .max_val_p (table_els_p - 1),
    .width_p   (lg_table_els_lp)
  ) idx_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (start_ok),
    .up_i      (resp_fire),
    .count_o   (idx_r)
  );

  bp_cfg_loader_counter #(
    .max_val_p (num_core_p - 1),
    .width_p   (lg_num_core_lp)
  ) core_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (start_ok),
    .up_i      (resp_fire & idx_last),
    .count_o   (core_r)
  );

  assign rom_addr_o = idx_r;
  assign cfg_core_o = core_r;
  assign cfg_addr_o = entry_addr_r;
  assign cfg_data_o = entry_data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r          <= e_idle;
      phase_r          <= e_phase_write;
      entry_addr_r     <= '0;
      entry_data_r     <= '0;
      cfg_v_o          <= 1'b0;
      cfg_w_o          <= 1'b0;
      cfg_resp_ready_o <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
      err_core_o       <= '0;
      err_idx_o        <= '0;
    end else begin
      case (state_r)
        e_idle, e_done: begin
          if (start_i) begin
            state_r    <= e_fetch;
            phase_r    <= e_phase_write;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_core_o <= '0;
            err_idx_o  <= '0;
          end
        end
        e_fetch: begin
          {entry_addr_r, entry_data_r} <= rom_data_i;
          cfg_v_o <= 1'b1;
          cfg_w_o <= (phase_r == e_phase_write);
          state_r <= e_send;
        end
        e_send: begin
          if (cfg_ready_i) begin
            cfg_v_o          <= 1'b0;
            cfg_w_o          <= 1'b0;
            cfg_resp_ready_o <= 1'b1;
            state_r          <= e_wait;
          end
        end
        e_wait: begin
          if (cfg_resp_v_i) begin
            cfg_resp_ready_o <= 1'b0;
            // Only the first mismatch of a run is recorded.
            if ((phase_r == e_phase_read) && (cfg_resp_data_i != entry_data_r) && !error_o) begin
              error_o    <= 1'b1;
              err_core_o <= core_r;
              err_idx_o  <= idx_r;
            end
            if (idx_last && core_last) begin
              if (phase_r == e_phase_write) begin
                phase_r <= e_phase_read;
                state_r <= e_fetch;
              end else begin
                state_r <= e_done;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
            end else begin
              state_r <= e_fetch;
            end
          end
        end
        default: begin
          state_r <= e_idle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: 2 cores x 3 entries, with a small
// per-core register model answering reads.
module tb_bp_cfg_loader;

  localparam int nc = 2;
  localparam int te = 3;
  localparam int aw = 16;
  localparam int dw = 64;

  typedef struct packed {
    logic          w;
    logic [0:0]    core;
    logic [aw-1:0] addr;
    logic [dw-1:0] data;
  } cmd_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    rom_addr_o;
  logic [aw+dw-1:0] rom_data_i;
  logic          cfg_v_o, cfg_w_o;
  logic [0:0]    cfg_core_o;
  logic [aw-1:0] cfg_addr_o;
  logic [dw-1:0] cfg_data_o;
  logic          cfg_ready_i = 1'b1;
  logic          cfg_resp_v_i = 1'b1;
  logic [dw-1:0] cfg_resp_data_i = '0;
  logic          cfg_resp_ready_o, busy_o, done_o, error_o;
  logic [0:0]    err_core_o;
  logic [1:0]    err_idx_o;

  int checks = 0;
  int errors = 0;
  cmd_t log_q[$];
  logic [dw-1:0] mem [nc][te];
  logic          flip [nc][te];

  bp_cfg_loader #(
    .num_core_p       (nc),
    .table_els_p      (te),
    .cfg_addr_width_p (aw),
    .cfg_data_width_p (dw)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .start_i          (start_i),
    .rom_addr_o       (rom_addr_o),
    .rom_data_i       (rom_data_i),
    .cfg_v_o          (cfg_v_o),
    .cfg_w_o          (cfg_w_o),
    .cfg_core_o       (cfg_core_o),
    .cfg_addr_o       (cfg_addr_o),
    .cfg_data_o       (cfg_data_o),
    .cfg_ready_i      (cfg_ready_i),
    .cfg_resp_v_i     (cfg_resp_v_i),
    .cfg_resp_data_i  (cfg_resp_data_i),
    .cfg_resp_ready_o (cfg_resp_ready_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .err_core_o       (err_core_o),
    .err_idx_o        (err_idx_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [aw-1:0] tbl_addr(input int i);
    return 16'h0100 + aw'(i);
  endfunction

  function automatic logic [dw-1:0] tbl_data(input int i);
    return 64'h1111_2222_3333_0000 + dw'(i);
  endfunction

  assign rom_data_i = (rom_addr_o < 2'(te)) ?
                      {tbl_addr(int'(rom_addr_o)), tbl_data(int'(rom_addr_o))} : '0;

  // Command log plus register model; reads return stored data, optionally corrupted.
  always @(posedge clk_i) begin
    if (reset_n_i && cfg_v_o && cfg_ready_i) begin
      int i;
      i = int'(cfg_addr_o - 16'h0100);
      log_q.push_back(cmd_t'{cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o});
      if (i < te) begin
        if (cfg_w_o) mem[cfg_core_o][i] <= cfg_data_o;
        cfg_resp_data_i <= cfg_w_o ? '0 : (mem[cfg_core_o][i] ^ dw'(flip[cfg_core_o][i]));
      end
    end
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t exp_cmd(input int k);
    cmd_t c;
    int   r;
    r      = k % (nc * te);
    c.w    = (k < nc * te);
    c.core = 1'(r / te);
    c.addr = tbl_addr(r % te);
    c.data = tbl_data(r % te);
    return c;
  endfunction

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 96'(log_q.size()), 96'(2 * nc * te));
    for (int k = 0; k < log_q.size() && k < 2 * nc * te; k++)
      chk($sformatf("%s_cmd%0d", tag, k), 96'(log_q[k]), 96'(exp_cmd(k)));
  endtask

  // Counts cycles from the start_i pulse to done_o; optionally re-pulses start_i mid-run.
  task automatic wait_done(input int mid_start, output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      start_i = (n == mid_start);
    end while (!done_o && n < 500);
    start_i = 1'b0;
  endtask

  task automatic bp_watch();
    int   t;
    cmd_t e;
    t = 0;
    e = exp_cmd(1);
    while (!(cfg_v_o && cfg_w_o && cfg_addr_o == e.addr && cfg_core_o == e.core) && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk("bp_seen", 96'(t < 100), 96'(1));
    cfg_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk($sformatf("bp_hold%0d", c),
          96'({cfg_v_o, cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o}), 96'({1'b1, e}));
    end
    cfg_ready_i = 1'b1;
  endtask

  initial begin
    int n;
    int t;
    for (int c = 0; c < nc; c++)
      for (int i = 0; i < te; i++) begin
        flip[c][i] = 1'b0;
        mem[c][i]  = '0;
      end

    #1 reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_v",    96'(cfg_v_o), 96'(0));
    chk("rst_w",    96'(cfg_w_o), 96'(0));
    chk("rst_busy", 96'(busy_o), 96'(0));
    chk("rst_done", 96'(done_o), 96'(0));
    chk("rst_err",  96'({error_o, err_core_o, err_idx_o}), 96'(0));
    chk("rst_rdy",  96'(cfg_resp_ready_o), 96'(0));
    chk("rst_addr", 96'(rom_addr_o), 96'(0));
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_busy", 96'(busy_o), 96'(0));

    // Basic run with a start_i pulse while busy.
    log_q.delete();
    start_i = 1'b1;
    wait_done(10, n);
    chk("basic_cycles", 96'(n), 96'(37));
    chk("basic_err", 96'(error_o), 96'(0));
    check_log("basic");
    repeat (3) @(negedge clk_i);
    chk("done_held", 96'(done_o), 96'(1));
    chk("done_busy", 96'(busy_o), 96'(0));

    // start_i from DONE.
    log_q.delete();
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("restart_done", 96'(done_o), 96'(0));
    chk("restart_busy", 96'(busy_o), 96'(1));
    wait_done(-1, n);
    chk("restart_cycles", 96'(n), 96'(36));
    check_log("restart");

    // Backpressure on entry 1.
    @(negedge clk_i);
    log_q.delete();
    start_i = 1'b1;
    fork
      wait_done(-1, n);
      bp_watch();
    join
    chk("bp_cycles", 96'(n), 96'(42));
    check_log("bp");

    // Readback mismatch, then rerun with an earlier mismatch.
    flip[1][2] = 1'b1;
    @(negedge clk_i);
    log_q.delete();
    start_i = 1'b1;
    wait_done(-1, n);
    chk("mm1_err", 96'({error_o, err_core_o, err_idx_o}), 96'({1'b1, 1'b1, 2'd2}));
    check_log("mm1");
    flip[0][0] = 1'b1;
    log_q.delete();
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("mm2_clear", 96'({error_o, err_core_o, err_idx_o}), 96'(0));
    wait_done(-1, n);
    chk("mm2_err", 96'({error_o, err_core_o, err_idx_o}), 96'({1'b1, 1'b0, 2'd0}));
    check_log("mm2");
    flip[0][0] = 1'b0;
    flip[1][2] = 1'b0;

    // Stray and delayed responses.
    @(negedge clk_i);
    log_q.delete();
    start_i = 1'b1;
    cfg_resp_v_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("stray_fetch_rdy", 96'(cfg_resp_ready_o), 96'(0));
    chk("stray_fetch_addr", 96'(rom_addr_o), 96'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    chk("stray_send", 96'({cfg_v_o, cfg_resp_ready_o}), 96'({1'b1, 1'b0}));
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_resp_v_i = 1'b0;
    chk("stray_wait_rdy", 96'(cfg_resp_ready_o), 96'(1));
    repeat (3) @(negedge clk_i);
    chk("delay_hold", 96'({cfg_resp_ready_o, rom_addr_o}), 96'({1'b1, 2'd0}));
    cfg_resp_v_i = 1'b1;
    @(negedge clk_i);
    chk("delay_accept", 96'({cfg_resp_ready_o, rom_addr_o}), 96'({1'b0, 2'd1}));
    wait_done(-1, n);
    chk("stray_err", 96'(error_o), 96'(0));
    check_log("stray");

    // Reset during SEND of the fifth write.
    @(negedge clk_i);
    log_q.delete();
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    t = 0;
    while (!(cfg_v_o && log_q.size() == 4) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk("rst_mid_reach", 96'({cfg_v_o, cfg_w_o, 8'(log_q.size())}), 96'({1'b1, 1'b1, 8'd4}));
    #1 reset_n_i = 1'b0;
    #1;
    chk("rst_mid_out", 96'({cfg_v_o, busy_o, cfg_resp_ready_o, rom_addr_o}), 96'(0));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    log_q.delete();
    start_i = 1'b1;
    wait_done(-1, n);
    chk("rst_rerun_cycles", 96'(n), 96'(37));
    check_log("rst_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
